// File: rtl/seq_decoder_pkg.sv
// Shared types, mode constants and one-hot helper for the sequential decoder.
package seq_decoder_pkg;

   // Widest output vector the onehot helper can produce.
   localparam int unsigned MAX_OUT = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_PULSE = 2'd2
   } state_e;

   localparam logic MODE_LEVEL = 1'b0;
   localparam logic MODE_PULSE = 1'b1;

   // One-hot of sel within num_out lines; all-zero when sel is out of range.
   function automatic logic [MAX_OUT-1:0] onehot(input logic [31:0] sel,
                                                 input int unsigned num_out);
      logic [MAX_OUT-1:0] res;
      res = '0;
      if (sel < num_out) begin
         res[sel[5:0]] = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/seq_decoder_onehot_dec.sv
// Combinational SEL_W-to-NUM_OUT decoder with enable and out-of-range flag.
module onehot_dec
   import seq_decoder_pkg::*;
#(
   parameter int unsigned SEL_W   = 2,
   parameter int unsigned NUM_OUT = 4
) (
   input  logic               en,
   input  logic [SEL_W-1:0]   sel,
   output logic [NUM_OUT-1:0] dec_c,
   output logic               oor_c
);

   logic [MAX_OUT-1:0] full;

   // Decode sel into a line, gated by enable; flag indices past the last line.
   always_comb begin
      full  = onehot(32'(sel), NUM_OUT);
      oor_c = (32'(sel) >= NUM_OUT);
      dec_c = en ? full[NUM_OUT-1:0] : '0;
   end

endmodule

// File: rtl/seq_decoder.sv
// Registered one-hot decoder with valid/ready commands, LEVEL and PULSE modes.
module seq_decoder
   import seq_decoder_pkg::*;
#(
   parameter int unsigned SEL_W     = 2,
   parameter int unsigned NUM_OUT   = 4,
   parameter int unsigned PULSE_LEN = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               en,
   input  logic [SEL_W-1:0]   sel,
   input  logic               mode,
   output logic [NUM_OUT-1:0] dec_out,
   output logic               busy,
   output logic               err
);

   localparam int unsigned CNT_W = $clog2(PULSE_LEN + 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_OUT-1:0] dec_q, dec_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;
   logic [NUM_OUT-1:0] dec_c;
   logic               oor_c;
   logic               accept;

   onehot_dec #(
      .SEL_W   (SEL_W),
      .NUM_OUT (NUM_OUT)
   ) u_dec (
      .en    (en),
      .sel   (sel),
      .dec_c (dec_c),
      .oor_c (oor_c)
   );

   // Ready depends on state alone so it never loops back from cmd_valid.
   assign cmd_ready = (state_q != ST_PULSE);
   assign accept    = cmd_valid && cmd_ready;

   // Next-state: clr beats commands; commands beat the pulse countdown.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;
      err_d   = 1'b0;
      if (clr) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         dec_d   = '0;
      end else if (accept) begin
         if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            dec_d   = '0;
         end else if (oor_c) begin
            err_d = 1'b1;
         end else if (mode == MODE_LEVEL) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            dec_d   = dec_c;
         end else begin
            state_d = ST_PULSE;
            cnt_d   = CNT_W'(PULSE_LEN - 1);
            dec_d   = dec_c;
         end
      end else if (state_q == ST_PULSE) begin
         if (cnt_q != '0) begin
            cnt_d = CNT_W'(cnt_q - 1'b1);
         end else begin
            state_d = ST_IDLE;
            dec_d   = '0;
         end
      end
      busy_d = |dec_d;
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dec_q   <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   assign dec_out = dec_q;
   assign busy    = busy_q;
   assign err     = err_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Three decoder configurations driven by shared stimulus, each against its own model.
module tb_seq_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       cmd_valid;
   logic       en;
   logic [2:0] sel;
   logic       mode;

   logic [3:0] dec0, dec2;
   logic [4:0] dec1;
   logic       rdy0, rdy1, rdy2;
   logic       busy0, busy1, busy2;
   logic       err0, err1, err2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   seq_decoder u0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
      .en(en), .sel(sel[1:0]), .mode(mode), .dec_out(dec0), .busy(busy0), .err(err0));

   seq_decoder #(.SEL_W(3), .NUM_OUT(5), .PULSE_LEN(3)) u1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
      .en(en), .sel(sel), .mode(mode), .dec_out(dec1), .busy(busy1), .err(err1));

   seq_decoder #(.PULSE_LEN(1)) u2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
      .en(en), .sel(sel[1:0]), .mode(mode), .dec_out(dec2), .busy(busy2), .err(err2));

   // Model state per instance: lit line (-1 none), visible pulse cycles left, error flag.
   int num_out [3] = '{4, 5, 4};
   int plen    [3] = '{4, 3, 1};
   int line    [3];
   int left    [3];
   bit m_err   [3];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference behaviour written from the command rules.
   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         int s;
         s = (i == 1) ? int'(sel) : int'(sel[1:0]);
         if (!rst_n || clr) begin
            line[i] = -1; left[i] = 0; m_err[i] = 1'b0;
         end else begin
            m_err[i] = 1'b0;
            if (cmd_valid && left[i] == 0) begin
               if (!en) begin
                  line[i] = -1;
               end else if (s >= num_out[i]) begin
                  m_err[i] = 1'b1;
               end else begin
                  line[i] = s;
                  if (mode) left[i] = plen[i];
               end
            end else if (left[i] > 0) begin
               left[i]--;
               if (left[i] == 0) line[i] = -1;
            end
         end
      end
   end

   function automatic logic [31:0] exp_dec(input int i);
      return (line[i] < 0) ? 32'd0 : (32'd1 << line[i]);
   endfunction

   task automatic compare_all();
      logic [31:0] d [3];
      logic        r [3];
      logic        b [3];
      logic        e [3];
      d[0] = 32'(dec0); d[1] = 32'(dec1); d[2] = 32'(dec2);
      r[0] = rdy0; r[1] = rdy1; r[2] = rdy2;
      b[0] = busy0; b[1] = busy1; b[2] = busy2;
      e[0] = err0; e[1] = err1; e[2] = err2;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d dec_out", i), d[i], exp_dec(i));
         chk($sformatf("u%0d busy", i), 32'(b[i]), 32'(line[i] >= 0));
         chk($sformatf("u%0d err", i), 32'(e[i]), 32'(m_err[i]));
         chk($sformatf("u%0d cmd_ready", i), 32'(r[i]), 32'(left[i] == 0));
      end
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
   endtask

   task automatic cmd(input logic v, input logic e, input logic [2:0] s, input logic m);
      cmd_valid = v; en = e; sel = s; mode = m;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0;
      cmd(1'b0, 1'b0, 3'd0, 1'b0);
      repeat (2) tick();
      chk("reset ready", 32'(rdy0), 32'd1);
      rst_n = 1'b1;
      repeat (5) tick();

      // LEVEL sweep with no gaps, then disable
      for (int s = 0; s < 4; s++) begin
         cmd(1'b1, 1'b1, 3'(s), 1'b0);
         tick();
      end
      cmd(1'b1, 1'b0, 3'd0, 1'b0);
      tick();
      chk("disable dec0", 32'(dec0), 32'd0);

      // PULSE sel=2 with a LEVEL command held through the pulse
      cmd(1'b1, 1'b1, 3'd2, 1'b1);
      tick();
      cmd(1'b1, 1'b1, 3'd1, 1'b0);
      repeat (6) tick();

      // Out of range while holding sel=1
      cmd(1'b1, 1'b1, 3'd1, 1'b0);
      tick();
      cmd(1'b1, 1'b1, 3'd6, 1'b0);
      tick();
      chk("oor hold", 32'(dec1), 32'h02);
      cmd(1'b0, 1'b1, 3'd0, 1'b0);
      repeat (2) tick();

      // Back-to-back PULSE commands alternating sel
      for (int k = 0; k < 6; k++) begin
         cmd(1'b1, 1'b1, 3'(k % 2), 1'b1);
         tick();
      end
      cmd(1'b0, 1'b0, 3'd0, 1'b0);
      repeat (4) tick();

      // clr in pulse cycle 2 with a command also offered
      cmd(1'b1, 1'b1, 3'd3, 1'b1);
      tick();
      cmd(1'b0, 1'b1, 3'd0, 1'b0);
      tick();
      clr = 1'b1;
      cmd(1'b1, 1'b1, 3'd0, 1'b0);
      tick();
      chk("clr drop dec0", 32'(dec0), 32'd0);
      clr = 1'b0;
      cmd(1'b0, 1'b0, 3'd0, 1'b0);
      repeat (2) tick();

      // Asynchronous reset in HOLD
      cmd(1'b1, 1'b1, 3'd1, 1'b0);
      tick();
      cmd(1'b0, 1'b0, 3'd0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst dec0", 32'(dec0), 32'd0);
      chk("async rst dec1", 32'(dec1), 32'd0);
      chk("async rst busy0", 32'(busy0), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Randomized traffic
      for (int k = 0; k < 600; k++) begin
         cmd(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 8),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         clr = ($urandom_range(0, 19) == 0);
         tick();
         chk("onehot0 dec1", 32'($countones(dec1) <= 1), 32'd1);
      end
      clr = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
